// File: rtl/pic_8259_pkg.sv
// Shared definitions for the 8259A init sequencer: FSM encoding, command bit positions, reset values.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pic_8259_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_ICW2 = 3'd1,
      ST_WAIT_ICW3 = 3'd2,
      ST_WAIT_ICW4 = 3'd3,
      ST_READY     = 3'd4
   } pic_state_t;

   // Command byte bit positions
   localparam int ICW1_MARK_BIT = 4;  // D4=1 with A0=0 marks ICW1
   localparam int OCW3_MARK_BIT = 3;  // D3 distinguishes OCW3 (1) from OCW2 (0)
   localparam int OCW3_RIS_BIT  = 0;
   localparam int OCW3_RR_BIT   = 1;
   localparam int OCW3_P_BIT    = 2;
   localparam int OCW3_SMM_BIT  = 5;
   localparam int OCW3_ESMM_BIT = 6;

   localparam logic [7:0] IMR_RESET = 8'hFF;

   // ICW1 is recognised in every state, so the decode lives here
   function automatic logic is_icw1(input logic a0, input logic [7:0] data);
      return !a0 && data[ICW1_MARK_BIT];
   endfunction

endpackage

// File: rtl/pic_write_capture.sv
// Samples the CPU write strobes and emits a one-cycle commit on the rising edge of write_bar.
// Latency: commit is asserted in the cycle write_bar returns high; a0/data are the previous-cycle samples.
// Backpressure: none; a held-low write commits exactly once when released.
// Ports: clk, reset (sync, active-high); chip_select_bar, write_bar, A0, data_bus_in from the bus;
//        commit, cmd_a0, cmd_data to the sequencer.
module pic_write_capture (
   input  logic       clk,
   input  logic       reset,
   input  logic       chip_select_bar,
   input  logic       write_bar,
   input  logic       A0,
   input  logic [7:0] data_bus_in,
   output logic       commit,
   output logic       cmd_a0,
   output logic [7:0] cmd_data
);

   logic       cs_q;
   logic       wr_q;
   logic       a0_q;
   logic [7:0] data_q;

   // wr_q resets high so the first cycle after reset cannot look like a write release
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_q   <= 1'b1;
         wr_q   <= 1'b1;
         a0_q   <= 1'b0;
         data_q <= 8'h00;
      end else begin
         cs_q   <= chip_select_bar;
         wr_q   <= write_bar;
         a0_q   <= A0;
         data_q <= data_bus_in;
      end
   end

   assign commit   = write_bar & ~wr_q & ~cs_q;
   assign cmd_a0   = a0_q;
   assign cmd_data = data_q;

endmodule

// File: rtl/pic_init_sequencer.sv
// 8259A ICW1-4 initialisation sequencer plus OCW1-3 decode and control-register file.
// Latency: registers/state update at the edge ending the commit cycle; flags pulse for one cycle after.
// Backpressure: none; every committed write is processed, unexpected writes are silently ignored.
// Ports: clk, reset (sync, active-high); bus write inputs; ICWx/OCWx one-cycle flags; init_done;
//        programmed fields (vector_base, ltim/sngl/ic4, icw3_reg, ICW4 fields, imr, ocw2_*, read_isr, smm);
//        poll_pulse.
module pic_init_sequencer
   import pic_8259_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       chip_select_bar,
   input  logic       write_bar,
   input  logic       A0,
   input  logic [7:0] data_bus_in,
   output logic       ICW1_flag,
   output logic       ICW2_flag,
   output logic       ICW3_flag,
   output logic       ICW4_flag,
   output logic       OCW1_flag,
   output logic       OCW2_flag,
   output logic       OCW3_flag,
   output logic       init_done,
   output logic [4:0] vector_base,
   output logic       ltim,
   output logic       sngl,
   output logic       ic4,
   output logic [7:0] icw3_reg,
   output logic       upm,
   output logic       aeoi,
   output logic [1:0] buf_ms,
   output logic       sfnm,
   output logic [7:0] imr,
   output logic [2:0] ocw2_cmd,
   output logic [2:0] ocw2_level,
   output logic       read_isr,
   output logic       poll_pulse,
   output logic       smm
);

   logic       commit;
   logic       cmd_a0;
   logic [7:0] cmd_data;
   pic_state_t state;

   pic_write_capture u_capture (
      .clk             (clk),
      .reset           (reset),
      .chip_select_bar (chip_select_bar),
      .write_bar       (write_bar),
      .A0              (A0),
      .data_bus_in     (data_bus_in),
      .commit          (commit),
      .cmd_a0          (cmd_a0),
      .cmd_data        (cmd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         ICW1_flag   <= 1'b0;
         ICW2_flag   <= 1'b0;
         ICW3_flag   <= 1'b0;
         ICW4_flag   <= 1'b0;
         OCW1_flag   <= 1'b0;
         OCW2_flag   <= 1'b0;
         OCW3_flag   <= 1'b0;
         poll_pulse  <= 1'b0;
         init_done   <= 1'b0;
         vector_base <= 5'h00;
         ltim        <= 1'b0;
         sngl        <= 1'b0;
         ic4         <= 1'b0;
         icw3_reg    <= 8'h00;
         upm         <= 1'b0;
         aeoi        <= 1'b0;
         buf_ms      <= 2'b00;
         sfnm        <= 1'b0;
         imr         <= IMR_RESET;
         ocw2_cmd    <= 3'b000;
         ocw2_level  <= 3'b000;
         read_isr    <= 1'b0;
         smm         <= 1'b0;
      end else begin
         // All flags are single-cycle pulses
         ICW1_flag  <= 1'b0;
         ICW2_flag  <= 1'b0;
         ICW3_flag  <= 1'b0;
         ICW4_flag  <= 1'b0;
         OCW1_flag  <= 1'b0;
         OCW2_flag  <= 1'b0;
         OCW3_flag  <= 1'b0;
         poll_pulse <= 1'b0;

         if (commit) begin
            if (is_icw1(cmd_a0, cmd_data)) begin
               // ICW1 restarts initialisation from any state
               ltim      <= cmd_data[3];
               sngl      <= cmd_data[1];
               ic4       <= cmd_data[0];
               imr       <= 8'h00;
               read_isr  <= 1'b0;
               smm       <= 1'b0;
               if (!cmd_data[0]) begin
                  upm    <= 1'b0;
                  aeoi   <= 1'b0;
                  buf_ms <= 2'b00;
                  sfnm   <= 1'b0;
               end
               ICW1_flag <= 1'b1;
               init_done <= 1'b0;
               state     <= ST_WAIT_ICW2;
            end else begin
               case (state)
                  ST_IDLE: begin
                     // Nothing but ICW1 is meaningful before initialisation starts
                  end
                  ST_WAIT_ICW2: begin
                     if (cmd_a0) begin
                        vector_base <= cmd_data[7:3];
                        ICW2_flag   <= 1'b1;
                        if (!sngl) begin
                           state <= ST_WAIT_ICW3;
                        end else if (ic4) begin
                           state <= ST_WAIT_ICW4;
                        end else begin
                           state     <= ST_READY;
                           init_done <= 1'b1;
                        end
                     end
                  end
                  ST_WAIT_ICW3: begin
                     if (cmd_a0) begin
                        icw3_reg  <= cmd_data;
                        ICW3_flag <= 1'b1;
                        if (ic4) begin
                           state <= ST_WAIT_ICW4;
                        end else begin
                           state     <= ST_READY;
                           init_done <= 1'b1;
                        end
                     end
                  end
                  ST_WAIT_ICW4: begin
                     if (cmd_a0) begin
                        upm       <= cmd_data[0];
                        aeoi      <= cmd_data[1];
                        buf_ms    <= cmd_data[3:2];
                        sfnm      <= cmd_data[4];
                        ICW4_flag <= 1'b1;
                        state     <= ST_READY;
                        init_done <= 1'b1;
                     end
                  end
                  ST_READY: begin
                     if (cmd_a0) begin
                        imr       <= cmd_data;
                        OCW1_flag <= 1'b1;
                     end else if (!cmd_data[OCW3_MARK_BIT]) begin
                        // D4 is known 0 here: ICW1 was decoded above
                        ocw2_cmd   <= cmd_data[7:5];
                        ocw2_level <= cmd_data[2:0];
                        OCW2_flag  <= 1'b1;
                     end else begin
                        if (cmd_data[OCW3_RR_BIT]) begin
                           read_isr <= cmd_data[OCW3_RIS_BIT];
                        end
                        if (cmd_data[OCW3_ESMM_BIT]) begin
                           smm <= cmd_data[OCW3_SMM_BIT];
                        end
                        poll_pulse <= cmd_data[OCW3_P_BIT];
                        OCW3_flag  <= 1'b1;
                     end
                  end
                  default: begin
                     state     <= ST_IDLE;
                     init_done <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Directed bench for pic_init_sequencer with a queue-based expectation model checked every cycle.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pic_init_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       chip_select_bar = 1'b1;
   logic       write_bar = 1'b1;
   logic       A0 = 1'b0;
   logic [7:0] data_bus_in = 8'h00;

   logic       ICW1_flag, ICW2_flag, ICW3_flag, ICW4_flag;
   logic       OCW1_flag, OCW2_flag, OCW3_flag;
   logic       init_done;
   logic [4:0] vector_base;
   logic       ltim, sngl, ic4;
   logic [7:0] icw3_reg;
   logic       upm, aeoi, sfnm;
   logic [1:0] buf_ms;
   logic [7:0] imr;
   logic [2:0] ocw2_cmd, ocw2_level;
   logic       read_isr, poll_pulse, smm;

   pic_init_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .chip_select_bar (chip_select_bar),
      .write_bar       (write_bar),
      .A0              (A0),
      .data_bus_in     (data_bus_in),
      .ICW1_flag       (ICW1_flag),
      .ICW2_flag       (ICW2_flag),
      .ICW3_flag       (ICW3_flag),
      .ICW4_flag       (ICW4_flag),
      .OCW1_flag       (OCW1_flag),
      .OCW2_flag       (OCW2_flag),
      .OCW3_flag       (OCW3_flag),
      .init_done       (init_done),
      .vector_base     (vector_base),
      .ltim            (ltim),
      .sngl            (sngl),
      .ic4             (ic4),
      .icw3_reg        (icw3_reg),
      .upm             (upm),
      .aeoi            (aeoi),
      .buf_ms          (buf_ms),
      .sfnm            (sfnm),
      .imr             (imr),
      .ocw2_cmd        (ocw2_cmd),
      .ocw2_level      (ocw2_level),
      .read_isr        (read_isr),
      .poll_pulse      (poll_pulse),
      .smm             (smm)
   );

   always #5 clk = ~clk;

   logic [6:0] flags;
   assign flags = {ICW1_flag, ICW2_flag, ICW3_flag, ICW4_flag, OCW1_flag, OCW2_flag, OCW3_flag};

   localparam int F_ICW1 = 6, F_ICW2 = 5, F_ICW3 = 4, F_ICW4 = 3;
   localparam int F_OCW1 = 2, F_OCW2 = 1, F_OCW3 = 0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Expectation model: initialisation is a list of still-owed ICW numbers
   bit         m_on = 0;
   bit         m_inited;
   int         pending[$];
   logic [6:0] e_flags = '0;
   logic       e_poll = 1'b0;
   logic       e_init;
   logic [4:0] e_vb;
   logic       e_ltim, e_sngl, e_ic4;
   logic [7:0] e_icw3;
   logic       e_upm, e_aeoi, e_sfnm;
   logic [1:0] e_buf;
   logic [7:0] e_imr;
   logic [2:0] e_cmd, e_lvl;
   logic       e_risr, e_smm;

   task automatic model_reset();
      m_inited = 0;
      pending.delete();
      e_flags = '0; e_poll = 0; e_init = 0;
      e_vb = 0; e_ltim = 0; e_sngl = 0; e_ic4 = 0; e_icw3 = 0;
      e_upm = 0; e_aeoi = 0; e_buf = 0; e_sfnm = 0;
      e_imr = 8'hFF; e_cmd = 0; e_lvl = 0; e_risr = 0; e_smm = 0;
   endtask

   task automatic model_apply(input logic a0, input logic [7:0] d);
      int w;
      if (!a0 && d[4]) begin
         e_ltim = d[3]; e_sngl = d[1]; e_ic4 = d[0];
         e_imr = 8'h00; e_risr = 0; e_smm = 0;
         if (!d[0]) begin e_upm = 0; e_aeoi = 0; e_buf = 0; e_sfnm = 0; end
         pending.delete();
         pending.push_back(2);
         if (!d[1]) pending.push_back(3);
         if (d[0])  pending.push_back(4);
         m_inited = 1; e_init = 0;
         e_flags[F_ICW1] = 1;
      end else if (!m_inited) begin
         // nothing before ICW1
      end else if (pending.size() > 0) begin
         if (a0) begin
            w = pending.pop_front();
            if (w == 2) begin e_vb = d[7:3]; e_flags[F_ICW2] = 1; end
            else if (w == 3) begin e_icw3 = d; e_flags[F_ICW3] = 1; end
            else begin
               e_upm = d[0]; e_aeoi = d[1]; e_buf = d[3:2]; e_sfnm = d[4];
               e_flags[F_ICW4] = 1;
            end
            if (pending.size() == 0) e_init = 1;
         end
      end else if (a0) begin
         e_imr = d; e_flags[F_OCW1] = 1;
      end else if (!d[3]) begin
         e_cmd = d[7:5]; e_lvl = d[2:0]; e_flags[F_OCW2] = 1;
      end else begin
         if (d[1]) e_risr = d[0];
         if (d[6]) e_smm = d[5];
         e_poll = d[2];
         e_flags[F_OCW3] = 1;
      end
   endtask

   always @(negedge clk) begin
      if (m_on) begin
         chk("flags", {1'b0, flags}, {1'b0, e_flags});
         chk("poll_pulse", {7'b0, poll_pulse}, {7'b0, e_poll});
         chk("init_done", {7'b0, init_done}, {7'b0, e_init});
         chk("vector_base", {3'b0, vector_base}, {3'b0, e_vb});
         chk("icw1_bits", {5'b0, ltim, sngl, ic4}, {5'b0, e_ltim, e_sngl, e_ic4});
         chk("icw3_reg", icw3_reg, e_icw3);
         chk("icw4_bits", {3'b0, sfnm, buf_ms, aeoi, upm}, {3'b0, e_sfnm, e_buf, e_aeoi, e_upm});
         chk("imr", imr, e_imr);
         chk("read_isr", {7'b0, read_isr}, {7'b0, e_risr});
         chk("smm", {7'b0, smm}, {7'b0, e_smm});
         if (e_flags[F_OCW2]) begin
            chk("ocw2", {2'b0, ocw2_cmd, ocw2_level}, {2'b0, e_cmd, e_lvl});
         end
         e_flags = '0;
         e_poll  = 0;
      end
   end

   // Called at a negedge; returns at the negedge where the resulting flags are visible
   task automatic do_write(input logic a0, input logic [7:0] d, input int nlow);
      chip_select_bar = 0; write_bar = 0; A0 = a0; data_bus_in = d;
      repeat (nlow) @(negedge clk);
      write_bar = 1; chip_select_bar = 1;
      @(posedge clk);
      model_apply(a0, d);
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1;
      @(posedge clk);
      model_reset();
      m_on = 1;
      repeat (n) @(negedge clk);
      reset = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset(2);
      chk("rst_imr", imr, 8'hFF);
      chk("rst_init", {7'b0, init_done}, 8'h00);

      // Single mode, no ICW4
      do_write(0, 8'h12, 1);
      chk("t1_icw1", {7'b0, ICW1_flag}, 8'h01);
      do_write(1, 8'h40, 1);
      chk("t1_icw2", {7'b0, ICW2_flag}, 8'h01);
      chk("t1_vb", {3'b0, vector_base}, 8'h08);
      chk("t1_sngl", {7'b0, sngl}, 8'h01);
      chk("t1_init", {7'b0, init_done}, 8'h01);
      repeat (2) @(negedge clk);

      // Cascade with ICW4, then OCW1
      do_write(0, 8'h11, 1);
      do_write(1, 8'h20, 1);
      do_write(1, 8'h04, 1);
      chk("t2_icw3", {7'b0, ICW3_flag}, 8'h01);
      do_write(1, 8'h03, 1);
      chk("t2_icw4", {7'b0, ICW4_flag}, 8'h01);
      chk("t2_icw3reg", icw3_reg, 8'h04);
      chk("t2_upm_aeoi", {6'b0, upm, aeoi}, 8'h03);
      chk("t2_init", {7'b0, init_done}, 8'h01);
      do_write(1, 8'hA5, 1);
      chk("t2_ocw1", {7'b0, OCW1_flag}, 8'h01);
      chk("t2_imr", imr, 8'hA5);

      // OCW2 / OCW3
      do_write(0, 8'h20, 1);
      chk("t3_ocw2", {7'b0, OCW2_flag}, 8'h01);
      chk("t3_cmd", {5'b0, ocw2_cmd}, 8'h01);
      do_write(0, 8'h0B, 1);
      chk("t3_ocw3", {7'b0, OCW3_flag}, 8'h01);
      chk("t3_risr", {7'b0, read_isr}, 8'h01);
      do_write(0, 8'h0C, 1);
      chk("t3_poll", {7'b0, poll_pulse}, 8'h01);
      @(negedge clk);
      chk("t3_poll_off", {7'b0, poll_pulse}, 8'h00);
      do_write(0, 8'h68, 1);
      chk("t3_smm", {7'b0, smm}, 8'h01);

      // Restart: ICW1 in READY, then again while owed ICW3
      do_write(0, 8'h11, 1);
      chk("t4_init_drop", {7'b0, init_done}, 8'h00);
      do_write(1, 8'h30, 1);
      do_write(0, 8'h11, 1);
      chk("t4_imr0", imr, 8'h00);
      do_write(1, 8'h48, 1);
      chk("t4_icw2_again", {7'b0, ICW2_flag}, 8'h01);
      do_write(1, 8'h02, 1);
      do_write(1, 8'h01, 1);
      chk("t4_init", {7'b0, init_done}, 8'h01);
      do_write(0, 8'h12, 1);
      chk("t4_upm_clr", {7'b0, upm}, 8'h00);

      // Ignored commits
      do_reset(2);
      do_write(1, 8'h55, 1);
      chk("t5_idle_a0", {1'b0, flags}, 8'h00);
      chk("t5_idle_imr", imr, 8'hFF);
      do_write(0, 8'h12, 1);
      do_write(0, 8'h20, 1);
      chk("t5_ocw2_ign", {1'b0, flags}, 8'h00);
      do_write(1, 8'h40, 1);
      chk("t5_icw2", {7'b0, ICW2_flag}, 8'h01);

      // Long write: single commit
      do_write(1, 8'h3C, 5);
      chk("t6_ocw1", {7'b0, OCW1_flag}, 8'h01);
      chk("t6_imr", imr, 8'h3C);
      @(negedge clk);
      chk("t6_once", {7'b0, OCW1_flag}, 8'h00);

      // Reset during a pending write
      chip_select_bar = 0; write_bar = 0; A0 = 1; data_bus_in = 8'h77;
      @(negedge clk);
      reset = 1;
      @(posedge clk);
      model_reset();
      repeat (2) @(negedge clk);
      write_bar = 1; chip_select_bar = 1; reset = 0;
      repeat (3) begin
         @(negedge clk);
         chk("t7_noflags", {poll_pulse, flags}, 8'h00);
      end
      chk("t7_imr", imr, 8'hFF);
      chk("t7_init", {7'b0, init_done}, 8'h00);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pic_init_sequencer.md
# pic_init_sequencer

Synchronous command sequencer and control-register file for the 8259A PIC core. It sits behind the Read/Write logic and watches CPU write cycles (chip_select_bar, write_bar, A0, data bus). It walks the ICW1→ICW2→[ICW3]→[ICW4] initialization sequence and, once initialized, decodes OCW1/OCW2/OCW3 writes. It holds every programmed field and issues one-cycle ICWx/OCWx flags that configure the priority resolver, IMR and cascade logic.

## Interface
- No parameters.
- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- chip_select_bar  in  1  active-low chip select, synchronous to clk
- write_bar  in  1  active-low write strobe, synchronous to clk
- A0  in  1  register address bit
- data_bus_in  in  8  CPU write data
- ICW1_flag, ICW2_flag, ICW3_flag, ICW4_flag, OCW1_flag, OCW2_flag, OCW3_flag  out  1 each  one-cycle commit pulses
- init_done  out  1  high in READY state
- vector_base  out  5  ICW2[7:3]
- ltim, sngl, ic4  out  1 each  ICW1 D3, D1, D0
- icw3_reg  out  8  cascade slave map / slave ID
- upm, aeoi, buf_ms, sfnm  out  1,1,2,1  ICW4 D0, D1, D3:D2, D4
- imr  out  8  interrupt mask register
- ocw2_cmd  out  3  OCW2 D7:D5 (R, SL, EOI); valid with OCW2_flag
- ocw2_level  out  3  OCW2 D2:D0; valid with OCW2_flag
- read_isr  out  1  0 = IRR selected for status read, 1 = ISR
- poll_pulse  out  1  one-cycle pulse, OCW3 with P=1
- smm  out  1  special mask mode

## Operation
- Write capture: sample cs_q, wr_q, a0_q, data_q every cycle. Commit fires in cycle N when write_bar=1 and, in cycle N-1, wr_q=0 and cs_q=0. The committed A0/data are the cycle N-1 samples. A write held for many cycles still commits exactly once.
- States: IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- ICW1 is a commit with A0=0 and D4=1. It is accepted in any state and always restarts the sequence. Effects:
  - latch ltim/sngl/ic4
  - imr←0x00, read_isr←0, smm←0
  - if D0=0: upm, aeoi, buf_ms and sfnm ← 0
  - → WAIT_ICW2
- WAIT_ICW2, A0=1: vector_base←D7:D3. Then → WAIT_ICW3 if sngl=0, else → WAIT_ICW4 if ic4=1, else → READY.
- WAIT_ICW3, A0=1: icw3_reg←data. Then → WAIT_ICW4 if ic4=1, else → READY.
- WAIT_ICW4, A0=1: latch ICW4 fields, → READY.
- READY:
  - A0=1 → OCW1: imr←data.
  - A0=0, D4=0, D3=0 → OCW2: present ocw2_cmd/level.
  - A0=0, D4=0, D3=1 → OCW3:
    - if RR (D1)=1: read_isr←RIS (D0)
    - if ESMM (D6)=1: smm←SMM (D5)
    - if P (D2)=1: poll_pulse
- Ignored commits (no state, register or flag change):
  - A0=1 in IDLE
  - A0=0/D4=0 in any state other than READY
- Reset values: state IDLE, all flags and pulses 0, init_done 0, imr 0xFF, all other registers 0. Sample registers reset with wr_q=1 so no commit can follow reset.

## Timing
- Commit detected in cycle N. Registers, state and init_done update at the edge ending cycle N, visible in N+1.
- Flags, ocw2 valid window and poll_pulse are high in cycle N+1 only.
- Minimum write spacing: one cycle low plus one cycle high. Back-to-back commits are each processed.
- Reset asserted mid-write discards the pending write. Reset has priority over commit in the same cycle.
- ICW1 arriving in READY drops init_done in N+1.

## Structure
- Shared package pic_8259_pkg holds:
  - state encoding
  - ICW/OCW bit-position constants (D4 ICW1 marker, D3 OCW3 marker, RR/RIS/P/ESMM/SMM)
  - reset value IMR_RESET=8'hFF
- One sub-module, pic_write_capture, holds the sample registers and commit-pulse generation and outputs commit, cmd_a0 and cmd_data. The FSM and register file stay in pic_init_sequencer.

## Test plan
- Single-mode, no ICW4: write 0x12 (A0=0), then 0x40 (A0=1) → ICW1_flag then ICW2_flag; sngl=1, vector_base=5'h08, init_done=1 after the second write; ICW3/ICW4 flags never pulse.
- Cascade with ICW4: write 0x11, 0x20, 0x04, 0x03 → four flags in order; icw3_reg=0x04, upm=1, aeoi=1; then OCW1 0xA5 → imr=0xA5, OCW1_flag.
- OCW2/OCW3 in READY: write 0x20 (A0=0) → OCW2_flag, ocw2_cmd=3'b001. Then 0x0B → OCW3_flag, read_isr=1. Then 0x0C → poll_pulse for one cycle. Then 0x68 → smm=1.
- Restart and ignore: ICW1 in WAIT_ICW3 → back to WAIT_ICW2, imr=0x00. A0=1 write in IDLE and OCW2 during WAIT_ICW2 → no flags, no state change.
- Reset edge cases: hold write_bar low 5 cycles → single commit. Assert reset while write_bar is low, release with write_bar high → no flag pulses, imr=0xFF, init_done=0.
